// File: rtl/alu_pkg.sv
// Shared ALU constants: control codes and the RV64 opcode/funct fields the decoder recognises.
package alu_pkg;

  // 4-bit ALU control codes, also consumed by the EX-stage ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_DWORD  = 3'b011;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // Control half of the ID/EX register (the datapath half is XLEN-wide and lives in the top)
  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       branch;
    logic [3:0] alu_ctrl;
    logic [4:0] rd;
  } idex_ctl_t;

  localparam idex_ctl_t IDEX_BUBBLE = '{valid: 1'b0, illegal: 1'b0, branch: 1'b0,
                                        alu_ctrl: ALU_AND, rd: 5'd0};

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of the supported RV64 subset into ALU control and operand select.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_control,
  output logic        use_imm,
  output logic        branch,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Anything not explicitly matched falls through as illegal with AND/zero controls
  always_comb begin
    alu_control = ALU_AND;
    use_imm     = 1'b0;
    branch      = 1'b0;
    illegal     = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        if (funct3 == F3_ADDSUB && funct7 == F7_BASE) begin
          alu_control = ALU_ADD;
          illegal     = 1'b0;
        end else if (funct3 == F3_ADDSUB && funct7 == F7_SUB) begin
          alu_control = ALU_SUB;
          illegal     = 1'b0;
        end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
          alu_control = ALU_AND;
          illegal     = 1'b0;
        end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
          alu_control = ALU_OR;
          illegal     = 1'b0;
        end
      end
      OP_LOAD, OP_STORE: begin
        if (funct3 == F3_DWORD) begin
          alu_control = ALU_ADD;
          use_imm     = 1'b1;
          illegal     = 1'b0;
        end
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          alu_control = ALU_SUB;
          branch      = 1'b1;
          illegal     = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register for the ALU path, with flush/stall handling and a saturating bubble counter.
module id_ex_alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  output logic [4:0]      ex_rd,
  output logic            ex_branch,
  output logic            ex_illegal,
  output logic [15:0]     bubble_count
);

  logic [3:0] dec_ctrl;
  logic       dec_use_imm;
  logic       dec_branch;
  logic       dec_illegal;

  alu_decode u_dec (
    .instr       (instr),
    .alu_control (dec_ctrl),
    .use_imm     (dec_use_imm),
    .branch      (dec_branch),
    .illegal     (dec_illegal)
  );

  idex_ctl_t       ctl_q, ctl_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [15:0]     bcnt_q, bcnt_d;

  // Next ID/EX contents: flush beats stall beats load; no instruction means bubble
  always_comb begin
    ctl_d = ctl_q;
    a_d   = a_q;
    b_d   = b_q;
    if (flush || (!stall && !in_valid)) begin
      ctl_d = IDEX_BUBBLE;
      a_d   = '0;
      b_d   = '0;
    end else if (!stall) begin
      if (dec_illegal) begin
        ctl_d         = IDEX_BUBBLE;
        ctl_d.illegal = 1'b1;
        a_d           = '0;
        b_d           = '0;
      end else begin
        ctl_d.valid    = 1'b1;
        ctl_d.illegal  = 1'b0;
        ctl_d.branch   = dec_branch;
        ctl_d.alu_ctrl = dec_ctrl;
        ctl_d.rd       = instr[11:7];
        a_d            = rs1_data;
        b_d            = dec_use_imm ? imm : rs2_data;
      end
    end
  end

  // Count edges where EX holds no live instruction; stick at all-ones
  always_comb begin
    bcnt_d = bcnt_q;
    if (!ctl_q.valid && bcnt_q != 16'hFFFF)
      bcnt_d = bcnt_q + 16'd1;
  end

  // Pipeline register and counter, synchronously cleared to a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q  <= IDEX_BUBBLE;
      a_q    <= '0;
      b_q    <= '0;
      bcnt_q <= '0;
    end else begin
      ctl_q  <= ctl_d;
      a_q    <= a_d;
      b_q    <= b_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign ex_valid     = ctl_q.valid;
  assign ex_illegal   = ctl_q.illegal;
  assign ex_branch    = ctl_q.branch;
  assign alu_control  = ctl_q.alu_ctrl;
  assign ex_rd        = ctl_q.rd;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign bubble_count = bcnt_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for id_ex_alu_issue with hand-computed expectations.
module tb_id_ex_alu_issue;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_data, rs2_data, imm;
  logic            stall, flush;
  logic            ex_valid;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [3:0]      alu_control;
  logic [4:0]      ex_rd;
  logic            ex_branch, ex_illegal;
  logic [15:0]     bubble_count;

  int errs = 0;
  int nchk = 0;

  id_ex_alu_issue #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .alu_a(alu_a),
    .alu_b(alu_b), .alu_control(alu_control), .ex_rd(ex_rd),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  // hand-encoded instructions
  localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_SUB  = 32'h402082B3; // sub x5,x1,x2
  localparam logic [31:0] I_AND  = 32'h0020F333; // and x6,x1,x2
  localparam logic [31:0] I_OR   = 32'h0020E3B3; // or  x7,x1,x2
  localparam logic [31:0] I_LD   = 32'h0100B203; // ld  x4,16(x1)
  localparam logic [31:0] I_SD   = 32'h0020B423; // sd  x2,8(x1)
  localparam logic [31:0] I_BEQ  = 32'h00208063; // beq x1,x2,0
  localparam logic [31:0] I_ADD0 = 32'h00208033; // add x0,x1,x2
  localparam logic [31:0] I_MUL  = 32'h022081B3; // mul: unsupported funct7
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] im);
    in_valid = 1'b1; instr = i; rs1_data = a; rs2_data = b; imm = im;
    step();
  endtask

  // ex_valid, alu_control, alu_a, alu_b, ex_rd, ex_branch, ex_illegal
  task automatic chk_ex(input string tag, input logic v, input logic [3:0] c,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic br, input logic il);
    chk({tag, ".valid"}, 64'(ex_valid), 64'(v));
    chk({tag, ".ctrl"},  64'(alu_control), 64'(c));
    chk({tag, ".a"},     alu_a, a);
    chk({tag, ".b"},     alu_b, b);
    chk({tag, ".rd"},    64'(ex_rd), 64'(rd));
    chk({tag, ".br"},    64'(ex_branch), 64'(br));
    chk({tag, ".ill"},   64'(ex_illegal), 64'(il));
  endtask

  logic [15:0] c0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0; imm = '0;
    stall = 1'b0; flush = 1'b0;
    step(); step();
    chk_ex("rst", 0, 4'b0000, 0, 0, 0, 0, 0);
    chk("rst.bcnt", 64'(bubble_count), 0);

    reset = 1'b0;
    step();
    chk("post_rst.valid", 64'(ex_valid), 0);
    chk("post_rst.bcnt", 64'(bubble_count), 1);

    issue(I_ADD, 5, 7, 64'hDEAD);
    chk_ex("add", 1, 4'b0010, 5, 7, 3, 0, 0);
    issue(I_LD, 100, 55, 16);
    chk_ex("ld", 1, 4'b0010, 100, 16, 4, 0, 0);
    issue(I_BEQ, 9, 9, 64'h44);
    chk_ex("beq", 1, 4'b0110, 9, 9, 0, 1, 0);
    issue(I_AND, 64'hF0F0, 64'h0FF0, 0);
    chk_ex("and", 1, 4'b0000, 64'hF0F0, 64'h0FF0, 6, 0, 0);
    issue(I_OR, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    chk_ex("or", 1, 4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 1, 7, 0, 0);
    issue(I_SD, 64'h1000, 64'h77, 8);
    chk_ex("sd", 1, 4'b0010, 64'h1000, 8, 8, 0, 0);
    issue(I_ADD0, 1, 2, 0);
    chk_ex("add_x0", 1, 4'b0010, 1, 2, 0, 0, 0);

    // sub captured, then held through three stalled cycles of junk input
    issue(I_SUB, 20, 3, 0);
    chk_ex("sub", 1, 4'b0110, 20, 3, 5, 0, 0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = k[0]; instr = (k == 1) ? I_BAD : I_AND;
      rs1_data = 64'(k + 50); rs2_data = 64'(k + 60);
      step();
      chk_ex($sformatf("stall%0d", k), 1, 4'b0110, 20, 3, 5, 0, 0);
    end

    // flush wins over stall; count does not move on this edge (EX was live)
    c0 = bubble_count;
    in_valid = 1'b1; instr = I_ADD; flush = 1'b1;
    step();
    chk_ex("flush_stall", 0, 4'b0000, 0, 0, 0, 0, 0);
    chk("flush_stall.bcnt", 64'(bubble_count), 64'(c0));
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    step();
    chk("bubble.bcnt", 64'(bubble_count), 64'(c0) + 1);
    chk_ex("idle", 0, 4'b0000, 0, 0, 0, 0, 0);

    // illegal encodings, then a legal one clears the flag
    issue(I_BAD, 3, 4, 5);
    chk_ex("bad", 0, 4'b0000, 0, 0, 0, 0, 1);
    issue(I_MUL, 3, 4, 5);
    chk_ex("mul", 0, 4'b0000, 0, 0, 0, 0, 1);
    issue(I_ADD, 11, 12, 0);
    chk_ex("add2", 1, 4'b0010, 11, 12, 3, 0, 0);

    // plain flush of a valid incoming instruction
    flush = 1'b1;
    issue(I_OR, 1, 2, 3);
    chk_ex("flush", 0, 4'b0000, 0, 0, 0, 0, 0);
    flush = 1'b0;

    // reset during a stall drops the held instruction
    issue(I_SUB, 8, 2, 0);
    chk("pre_rst.valid", 64'(ex_valid), 1);
    stall = 1'b1; reset = 1'b1;
    step();
    chk_ex("rst_stall", 0, 4'b0000, 0, 0, 0, 0, 0);
    chk("rst_stall.bcnt", 64'(bubble_count), 0);
    reset = 1'b0;
    step();
    chk("rst_stall.after", 64'(ex_valid), 0);
    stall = 1'b0; in_valid = 1'b0;

    // saturation: 65540 idle edges after reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (65534) step();
    chk("cnt_65534", 64'(bubble_count), 64'd65534);
    repeat (6) step();
    chk("sat", 64'(bubble_count), 64'hFFFF);
    repeat (3) step();
    chk("sat_hold", 64'(bubble_count), 64'hFFFF);
    reset = 1'b1;
    step();
    chk("sat_rst", 64'(bubble_count), 0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
ID_EX_ALU_ISSUE -- requirements
Module: id_ex_alu_issue

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning datapath width of operands and immediate.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk: input, 1 bit, rising-edge clock for all state.
REQ-004 Port reset: input, 1 bit, synchronous active-high reset.
REQ-005 Port in_valid: input, 1 bit, decode stage presents an instruction this cycle.
REQ-006 Port instr: input, 32 bits, RV64 instruction word.
REQ-007 Port rs1_data: input, XLEN bits, register-file read of rs1.
REQ-008 Port rs2_data: input, XLEN bits, register-file read of rs2.
REQ-009 Port imm: input, XLEN bits, sign-extended immediate from the immediate generator.
REQ-010 Port stall: input, 1 bit, hold the ID/EX register contents.
REQ-011 Port flush: input, 1 bit, replace the ID/EX register contents with a bubble.
REQ-012 Port ex_valid: output, 1 bit, the registered instruction is live in EX.
REQ-013 Port alu_a: output, XLEN bits, registered ALU operand A.
REQ-014 Port alu_b: output, XLEN bits, registered ALU operand B, rs2_data or imm.
REQ-015 Port alu_control: output, 4 bits, registered ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or.
REQ-016 Port ex_rd: output, 5 bits, registered destination register index, instr[11:7].
REQ-017 Port ex_branch: output, 1 bit, registered beq flag; EX consumes ALU Zero.
REQ-018 Port ex_illegal: output, 1 bit, registered flag for an unsupported encoding.
REQ-019 Port bubble_count: output, 16 bits, count of EX cycles with ex_valid=0 since reset.

Function
REQ-020 The block SHALL decode combinationally and capture the result at the next rising clk edge, giving exactly 1-cycle latency from in_valid to ex_valid.
REQ-021 The block SHALL decode opcode 0110011 with funct3 000 and funct7 0000000 as add (alu_control 0010), using alu_b = rs2_data.
REQ-022 The block SHALL decode opcode 0110011 with funct3 000 and funct7 0100000 as sub (0110), using alu_b = rs2_data.
REQ-023 The block SHALL decode opcode 0110011 with funct3 111 and funct7 0 as and (0000), and with funct3 110 and funct7 0 as or (0001), using alu_b = rs2_data.
REQ-024 The block SHALL decode opcodes 0000011 (ld, funct3 011) and 0100011 (sd, funct3 011) as add (0010), using alu_b = imm.
REQ-025 The block SHALL decode opcode 1100011 with funct3 000 (beq) as sub (0110), using alu_b = rs2_data and ex_branch = 1.
REQ-026 The block SHALL set alu_a = rs1_data for every legal encoding.
REQ-027 For any other encoding with in_valid=1, the block SHALL capture ex_valid=0, ex_illegal=1, alu_control=0000 and alu_a = alu_b = 0.
REQ-028 Update priority SHALL be reset, then flush, then stall, then load.
REQ-029 A flush SHALL load a bubble: ex_valid=0, ex_illegal=0, ex_branch=0, alu_control=0000, alu_a=0, alu_b=0, ex_rd=0.
REQ-030 When flush and stall are both 1, the flush SHALL take effect and the bubble SHALL be loaded.
REQ-031 While stall=1 and flush=0, all registered outputs SHALL hold their values, regardless of in_valid or instr.
REQ-032 With in_valid=0 and no stall, the block SHALL load a bubble.
REQ-033 bubble_count SHALL increment by 1 on each rising edge at which the registered ex_valid is 0, excluding reset cycles.
REQ-034 bubble_count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-035 An instruction with ex_rd = 0 SHALL still issue with ex_valid=1; suppressing the x0 write is not this block's job.

Reset
REQ-036 While reset=1 at a rising edge, all outputs SHALL take their bubble values and bubble_count SHALL be 0.
REQ-037 Reset asserted mid-stall SHALL discard the held instruction.
REQ-038 ex_valid SHALL be 0 in the first cycle after reset is released.

Structure
REQ-039 The 4-bit ALU control codes and the opcode, funct3 and funct7 constants SHALL be defined in a shared package, alu_pkg, which the ALU also uses.
REQ-040 Decode SHALL be a separate combinational sub-module, alu_decode (instr in; alu_control, use_imm, branch and illegal out), and the register and counter logic SHALL live in id_ex_alu_issue.

Verification
REQ-041 Scenario: add x3,x1,x2 with rs1_data=5, rs2_data=7, in_valid=1 -> next cycle ex_valid=1, alu_control=0010, alu_a=5, alu_b=7, ex_rd=3.
REQ-042 Scenario: ld x4,16(x1) with rs1_data=100, imm=16 -> alu_control=0010, alu_b=16; beq with rs1_data = rs2_data = 9 -> alu_control=0110, ex_branch=1.
REQ-043 Scenario: sub issued, then stall=1 for 3 cycles with different instr values applied -> outputs stay identical to the sub capture for all 3 cycles.
REQ-044 Scenario: stall=1 and flush=1 in the same cycle -> next cycle ex_valid=0, alu_control=0000, and bubble_count increments by 1.
REQ-045 Scenario: instr=32'h0000_007F with in_valid=1 -> ex_illegal=1, ex_valid=0; the next legal instruction clears ex_illegal.
REQ-046 Scenario: hold in_valid=0 for 65540 cycles after reset -> bubble_count=16'hFFFF and stays there; then assert reset -> bubble_count=0.
